// File: rtl/fifo_rd_stream.sv
// Converts a 1-cycle-latency FIFO read port (re/empty) into a valid/ready stream with burst framing (m_last).
// Latency: 2 cycles from fifo_empty falling to m_valid; sustains one beat per cycle.
// Backpressure: a 2-entry skid buffer absorbs the in-flight read; no read is issued that could overflow it.
// Optional m_parity output is enabled by defining FIFO_RD_STREAM_PARITY_EN.
module fifo_rd_stream #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_re,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef FIFO_RD_STREAM_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [1:0]        cnt;
    logic              inflight;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [BEAT_W-1:0] beat;

    logic              pop;
    logic [2:0]        occ_next;
    logic [DATA_W-1:0] buf0_nxt;
    logic [DATA_W-1:0] buf1_nxt;

    assign pop      = m_valid & m_ready;
    assign occ_next = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_re  = !rst & !fifo_empty & (occ_next < 3'd2);

    assign m_valid  = (cnt != 2'd0);
    assign m_data   = buf0;
    assign m_last   = m_valid & (beat == LAST_BEAT);

`ifdef FIFO_RD_STREAM_PARITY_EN
    assign m_parity = m_valid & (^m_data);
`endif

    // occ_next already counts the arriving word, so it lands in slot occ_next-1
    always_comb begin
        buf0_nxt = pop ? buf1 : buf0;
        buf1_nxt = buf1;
        if (inflight) begin
            if (occ_next == 3'd1) begin
                buf0_nxt = fifo_rd_data;
            end else begin
                buf1_nxt = fifo_rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
            beat     <= '0;
        end else begin
            cnt      <= occ_next[1:0];
            inflight <= fifo_re;
            buf0     <= buf0_nxt;
            buf1     <= buf1_nxt;
            if (pop) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: upstream FIFO modelled as a queue, output checked against word order and burst position.
module tb_fifo_rd_stream;
    localparam int DW = 32;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_re;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef FIFO_RD_STREAM_PARITY_EN
    logic          m_parity;
`endif

    fifo_rd_stream #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_re     (fifo_re),
        .fifo_rd_data(fifo_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
`ifdef FIFO_RD_STREAM_PARITY_EN
        ,
        .m_parity    (m_parity)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] src_q[$];   // words still in the upstream FIFO
    logic [DW-1:0] own_q[$];   // words read out of the FIFO but not yet delivered
    int            beats, delivered, re_cnt, cyc, first_valid, first_last, pushed;
    bit            any_valid;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    int            pop_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered just after a falling edge with inputs already set.
    task automatic cycle();
        bit pop;
        bit re;
        #1;
        pop = m_valid & m_ready;
        re  = fifo_re;
        if (m_valid) any_valid = 1'b1;
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (prev_hold) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
        end
        if (!m_valid) chk("last_idle", m_last, 0);
        if (pop) begin
            chk("beat_source", own_q.size() != 0, 1);
            if (own_q.size() != 0) chk("order", m_data, own_q[0]);
            chk("last", m_last, (beats % BL) == BL - 1);
            if (m_last && first_last < 0) first_last = delivered + 1;
        end
`ifdef FIFO_RD_STREAM_PARITY_EN
        chk("parity", m_parity, m_valid & (^m_data));
`endif
        prev_hold = m_valid & !m_ready;
        prev_data = m_data;
        @(posedge clk);
        #1;
        if (pop) begin
            if (own_q.size() != 0) void'(own_q.pop_front());
            beats++;
            delivered++;
            pop_cyc.push_back(cyc);
        end
        if (re) begin
            re_cnt++;
            if (src_q.size() == 0) begin
                chk("re_on_empty", re, 0);
                fifo_rd_data = $urandom;
            end else begin
                fifo_rd_data = src_q.pop_front();
                own_q.push_back(fifo_rd_data);
            end
        end else begin
            fifo_rd_data = $urandom;
        end
        chk("no_overflow", own_q.size() <= 2, 1);
        fifo_empty = (src_q.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_re", fifo_re, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        own_q.delete();
        pop_cyc.delete();
        beats = 0; delivered = 0; re_cnt = 0; cyc = 0;
        first_valid = -1; first_last = -1; any_valid = 1'b0;
        prev_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_rd_data = $urandom;
        fifo_empty = (src_q.size() == 0);
        @(negedge clk);
    endtask

    initial begin
        // Preloaded FIFO, continuous ready: full-rate bursts with m_last on 0x8 and 0x10
        src_q.delete();
        for (int i = 1; i <= 16; i++) src_q.push_back(DW'(i));
        fifo_empty = 1'b0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && delivered < 16; i++) cycle();
        chk("t1_delivered", delivered, 16);
        chk("t1_latency", first_valid, 2);
        chk("t1_first_last", first_last, 8);
        if (pop_cyc.size() == 16) chk("t1_back_to_back", pop_cyc[15] - pop_cyc[0], 15);

        // Stalled consumer: only two reads fit, head held stable, nothing lost afterwards
        src_q.delete();
        for (int i = 1; i <= 4; i++) src_q.push_back(DW'(i));
        do_reset();
        m_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_re_pulses", re_cnt, 2);
        chk("t2_head", m_data, 1);
        chk("t2_valid", m_valid, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 20 && delivered < 4; i++) cycle();
        chk("t2_delivered", delivered, 4);
        chk("t2_fifo_drained", src_q.size(), 0);

        // Alternating ready over a 20-word stream
        src_q.delete();
        for (int i = 0; i < 20; i++) src_q.push_back($urandom);
        do_reset();
        for (int i = 0; i < 200 && delivered < 20; i++) begin
            m_ready = (i % 2 == 0);
            cycle();
        end
        chk("t3_delivered", delivered, 20);

        // Reset after beat 3: burst position restarts at beat 0
        src_q.delete();
        for (int i = 0; i < 32; i++) src_q.push_back($urandom);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 20 && delivered < 3; i++) cycle();
        chk("t4_pre_beats", delivered, 3);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 40 && delivered < 9; i++) cycle();
        chk("t4_post_beats", delivered, 9);
        chk("t4_first_last", first_last, 8);

        // Permanently empty FIFO
        src_q.delete();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            m_ready = $urandom_range(0, 1);
            cycle();
        end
        chk("t5_no_re", re_cnt, 0);
        chk("t5_no_valid", any_valid, 0);

        // Random producer and consumer, then drain
        src_q.delete();
        pushed = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                src_q.push_back($urandom);
                pushed++;
                fifo_empty = 1'b0;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 400 && (src_q.size() != 0 || own_q.size() != 0); i++) cycle();
        chk("t6_delivered", delivered, pushed);

`ifdef FIFO_RD_STREAM_PARITY_EN
        src_q.delete();
        src_q.push_back(32'h0000_0007);
        src_q.push_back(32'h0000_0003);
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10 && !m_valid; i++) cycle();
        chk("par_data7", m_data, 32'h7);
        chk("par_odd", m_parity, 1);
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        for (int i = 0; i < 10 && !m_valid; i++) cycle();
        chk("par_data3", m_data, 32'h3);
        chk("par_even", m_parity, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Downstream read-side stage of the synchronous FIFO: converts the FIFO's re/empty, 1-cycle-latency read port into a valid/ready stream with burst framing.

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data width of FIFO read data and stream data.
REQ-002 The block SHALL have parameter BURST_LEN, default 8, giving the number of beats per burst; legal range is 1..256.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: the FIFO empty flag.
REQ-006 The block SHALL have port fifo_re, output, 1 bit: the FIFO read enable.
REQ-007 The block SHALL have port fifo_rd_data, input, DATA_W bits: FIFO read data, valid on the cycle after fifo_re.
REQ-008 The block SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-009 The block SHALL have port m_ready, input, 1 bit: stream consumer ready.
REQ-010 The block SHALL have port m_data, output, DATA_W bits: stream data.
REQ-011 The block SHALL have port m_last, output, 1 bit: final beat of the current burst.

Function
REQ-012 The block SHALL hold a 2-entry skid buffer (occupancy cnt 0..2) and an inflight flag, set on the cycle after fifo_re=1 and clear otherwise.
REQ-013 The block SHALL define pop = m_valid & m_ready, and a beat SHALL transfer only on a cycle where pop=1.
REQ-014 The block SHALL drive fifo_re = !rst & !fifo_empty & (cnt + inflight - pop < 2), combinationally.
REQ-015 The block SHALL write fifo_rd_data into the buffer tail on every edge where inflight=1, with no loss when a push and a pop occur on the same edge.
REQ-016 The block SHALL drive m_valid = (cnt != 0), m_data = buffer head, both registered-state derived with no combinational path from m_ready.
REQ-017 The block SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-018 The block SHALL sustain one beat per cycle when fifo_empty=0 and m_ready=1 continuously; first-word latency from fifo_empty falling SHALL be 2 cycles to m_valid.
REQ-019 The block SHALL preserve FIFO order and never duplicate or drop a word.
REQ-020 The block SHALL keep a beat counter 0..BURST_LEN-1 that increments on pop and wraps to 0 after BURST_LEN-1.
REQ-021 The block SHALL drive m_last = m_valid & (beat counter == BURST_LEN-1); with BURST_LEN=1, m_last = m_valid.
REQ-022 The block SHALL never issue fifo_re when cnt=2 and no pop occurs, so buffer overflow is impossible.
REQ-023 The block SHALL hold all outputs and state while m_ready=0 and the buffer is full, regardless of fifo_empty.

Reset
REQ-024 While rst=1, the block SHALL force fifo_re=0, m_valid=0, m_last=0, m_data=0, cnt=0, inflight=0, beat counter=0.
REQ-025 The block SHALL discard buffered and in-flight words on reset mid-burst, and the next burst after release SHALL start at beat 0.
REQ-026 The block SHALL first assert fifo_re no earlier than the first rising edge after rst deasserts.

Configuration
REQ-027 With macro FIFO_RD_STREAM_PARITY_EN defined, the block SHALL add output m_parity (1 bit) = XOR reduction of m_data, qualified by m_valid and 0 in reset.
REQ-028 Without FIFO_RD_STREAM_PARITY_EN, port m_parity and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 Verification SHALL cover: FIFO preloaded with 0x1..0x10, m_ready=1, BURST_LEN=8 -> 16 beats on consecutive cycles in order, with m_last on 0x8 and 0x10.
REQ-030 Verification SHALL cover: FIFO holds 4 words, m_ready=0 for 10 cycles -> exactly 2 fifo_re pulses, m_data=0x1 stable; m_ready=1 -> 0x1..0x4 delivered with none lost.
REQ-031 Verification SHALL cover: m_ready toggling 1,0,1,0 with a 20-word stream -> all 20 words delivered in order, and fifo_re never asserts with cnt=2 and no pop.
REQ-032 Verification SHALL cover: rst pulse after beat 3 of a burst -> outputs 0 during reset; post-reset, the next accepted word has beat counter 0 and m_last only on the 8th subsequent beat.
REQ-033 Verification SHALL cover: fifo_empty=1 throughout -> fifo_re=0 and m_valid=0 indefinitely.
REQ-034 Verification SHALL cover: with FIFO_RD_STREAM_PARITY_EN, m_data=0x00000007 -> m_parity=1, and m_data=0x00000003 -> m_parity=0.
